// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level single-master I2C initiator turning START/WRITE/READ/STOP into open-drain SDA/SCL
// Ports: clk/rst (sync, active-high); cmd_valid/cmd_ready/cmd/wdata/cmd_ack command handshake;
//   rsp_valid/rdata/nak completion; busy = bus owned; sda_in/scl_in bus levels; sda_oe/scl_oe 1 = pull low.
// Optional: define I2C_MASTER_STRETCH_EN to honour slave clock stretching during SCL-high phases.
module i2c_byte_master #(
  parameter int QDIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
  input  logic       cmd_ack,
  output logic       rsp_valid,
  output logic [7:0] rdata,
  output logic       nak,
  output logic       busy,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       sda_oe,
  output logic       scl_oe
);
  localparam int CW = $clog2(QDIV);
  typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} state_t;
  state_t st_q;
  logic [CW-1:0] cnt_q;
  logic [1:0] q_q;
  logic [3:0] slot_q;
  logic rd_q, ack_q;
  logic [7:0] sh_q;
  logic [1:0] sda_s_q, scl_s_q;
  logic tick, hold;
  assign tick = cnt_q == CW'(QDIV - 1);
`ifdef I2C_MASTER_STRETCH_EN
  // Hold once the synchronizer has had time to see our own release, so an unstretched slot keeps exact timing.
  assign hold = (st_q == BIT || st_q == STOP) && q_q == 2'd2 && cnt_q == CW'(2) && !scl_s_q[1];
`else
  logic unused_scl;
  assign unused_scl = scl_s_q[1];
  assign hold = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      q_q <= '0;
      slot_q <= '0;
      rd_q <= 1'b0;
      ack_q <= 1'b0;
      sh_q <= '0;
      sda_s_q <= '0;
      scl_s_q <= '0;
      sda_oe <= 1'b0;
      scl_oe <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy <= 1'b0;
      nak <= 1'b0;
      rdata <= '0;
    end else begin
      sda_s_q <= {sda_s_q[0], sda_in};
      scl_s_q <= {scl_s_q[0], scl_in};
      rsp_valid <= 1'b0;
      cnt_q <= (tick || st_q == IDLE || st_q == DONE) ? '0 : hold ? cnt_q : cnt_q + 1'b1;
      case (st_q)
        IDLE, DONE: begin
          st_q <= IDLE;
          if (cmd_valid && cmd_ready) begin
            q_q <= '0;
            slot_q <= '0;
            rd_q <= cmd == 2'd2;
            ack_q <= cmd_ack;
            sh_q <= wdata;
            if (cmd == 2'd0) begin
              st_q <= START;
              cmd_ready <= 1'b0;
              sda_oe <= 1'b0;
            end else if (!busy) begin
              st_q <= DONE;
              rsp_valid <= 1'b1;
              nak <= cmd != 2'd3;
            end else if (cmd == 2'd3) begin
              st_q <= STOP;
              cmd_ready <= 1'b0;
              sda_oe <= 1'b1;
            end else begin
              st_q <= BIT;
              cmd_ready <= 1'b0;
              sda_oe <= cmd == 2'd1 && !wdata[7];
            end
          end
        end
        START: if (tick) begin
          q_q <= q_q + 1'b1;
          if (q_q == 2'd0) scl_oe <= 1'b0;
          if (q_q == 2'd1) sda_oe <= 1'b1;
          if (q_q == 2'd2) scl_oe <= 1'b1;
          if (q_q == 2'd3) begin
            st_q <= DONE;
            rsp_valid <= 1'b1;
            cmd_ready <= 1'b1;
            nak <= 1'b0;
            busy <= 1'b1;
          end
        end
        STOP: if (tick) begin
          q_q <= q_q + 1'b1;
          if (q_q == 2'd0) scl_oe <= 1'b0;
          if (q_q == 2'd2) sda_oe <= 1'b0;
          if (q_q == 2'd3) begin
            st_q <= DONE;
            rsp_valid <= 1'b1;
            cmd_ready <= 1'b1;
            nak <= 1'b0;
            busy <= 1'b0;
          end
        end
        BIT: if (tick) begin
          q_q <= q_q + 1'b1;
          if (q_q == 2'd1) scl_oe <= 1'b0;
          // One shifter serves both directions: WRITE drives from sh_q[7], READ collects into the LSB.
          if (q_q == 2'd2) begin
            if (slot_q[3]) nak <= !rd_q && sda_s_q[1];
            else sh_q <= {sh_q[6:0], sda_s_q[1]};
          end
          if (q_q == 2'd3) begin
            scl_oe <= 1'b1;
            slot_q <= slot_q + 1'b1;
            sda_oe <= slot_q == 4'd7 ? rd_q && ack_q : !slot_q[3] && !rd_q && !sh_q[7];
            if (slot_q[3]) begin
              st_q <= DONE;
              rsp_valid <= 1'b1;
              cmd_ready <= 1'b1;
              if (rd_q) rdata <= sh_q;
            end
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: directed bench with behavioural 7-bit slave at 0x70 and a byte scoreboard
module tb_i2c_byte_master;
  localparam int QDIV = 4;
  localparam int LBIT = 36 * QDIV + 1;
  localparam int LSS = 4 * QDIV + 1;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0, cmd_ack = 1'b0;
  logic [1:0] cmd = '0;
  logic [7:0] wdata = '0;
  logic cmd_ready, rsp_valid, nak, busy, sda_oe, scl_oe;
  logic [7:0] rdata;
  logic slv_sda = 1'b0, hold = 1'b0;
  wire scl_bus = !(scl_oe | hold);
  wire sda_bus = !(sda_oe | slv_sda);
  i2c_byte_master #(.QDIV(QDIV)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .wdata(wdata), .cmd_ack(cmd_ack), .rsp_valid(rsp_valid), .rdata(rdata), .nak(nak),
    .busy(busy), .sda_in(sda_bus), .scl_in(scl_bus), .sda_oe(sda_oe), .scl_oe(scl_oe)
  );
  int n_assert = 0, n_fail = 0, rsp_cnt = 0, restarts = 0, bitcnt = 0, txi = 0, rel_n = 0;
  logic active = 1'b0, in_txn = 1'b0, rdmode = 1'b0, pend_rd = 1'b0, addr_ph = 1'b0;
  logic rise_low = 1'b0, mack_oe = 1'b0, arm = 1'b0, r_nak;
  logic [7:0] sr = '0, tx = '0, r_rdata;
  logic [7:0] tx_tab [2] = '{8'hA5, 8'h3C};
  logic [7:0] rx_q [$];
  typedef struct {logic [7:0] b; logic n;} exp_t;
  exp_t exp_q [$];
  always @(posedge clk) if (rsp_valid) rsp_cnt++;
  always @(negedge sda_bus) begin
    #1;
    if (scl_bus) begin
      if (in_txn) restarts++;
      in_txn = 1'b1; active = 1'b1; addr_ph = 1'b1; rdmode = 1'b0; pend_rd = 1'b0;
      bitcnt = 0; slv_sda = 1'b0;
    end
  end
  always @(posedge sda_bus) begin
    #1;
    if (scl_bus) begin in_txn = 1'b0; active = 1'b0; slv_sda = 1'b0; end
    else rise_low = 1'b1;
  end
  always @(posedge scl_bus) if (active) begin
    if (bitcnt < 8) begin
      if (!rdmode) sr = {sr[6:0], sda_bus};
      bitcnt++;
    end else begin
      if (rdmode) begin mack_oe = sda_oe; if (sda_bus) active = 1'b0; end
      bitcnt = 9;
    end
  end
  always @(negedge scl_bus) if (active) begin
    if (bitcnt == 8) begin
      if (rdmode) slv_sda = 1'b0;
      else begin
        rx_q.push_back(sr);
        if (addr_ph && sr[7:1] != 7'h70) active = 1'b0;
        else slv_sda = 1'b1;
        pend_rd = addr_ph && sr[0];
        addr_ph = 1'b0;
      end
    end else if (bitcnt == 9) begin
      bitcnt = 0;
      if (pend_rd) begin rdmode = 1'b1; pend_rd = 1'b0; end
      if (rdmode) begin tx = tx_tab[txi % 2]; txi++; slv_sda = !tx[7]; end
      else slv_sda = 1'b0;
    end else if (rdmode && bitcnt > 0) slv_sda = !tx[7 - bitcnt];
  end
  always @(posedge scl_oe) if (arm) begin
    rel_n++;
    if (rel_n == 3) begin
      hold = 1'b1;
      @(negedge scl_oe);
      repeat (41) @(negedge clk);
      hold = 1'b0;
    end
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask
  task automatic do_cmd(input logic [1:0] c, input logic [7:0] wd, input logic a, output int lat);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 1000) begin @(negedge clk); w++; end
    cmd = c; wdata = wd; cmd_ack = a; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
    r_nak = nak; r_rdata = rdata;
  endtask
  task automatic ss(input logic [1:0] c, input logic ebusy, input string tag);
    int lat;
    do_cmd(c, 8'h00, 1'b0, lat);
    chk({tag, " lat"}, lat, LSS);
    chk({tag, " nak"}, r_nak, 0);
    chk({tag, " busy"}, busy, ebusy);
  endtask
  task automatic wr(input logic [7:0] wd, input logic en, input int elat, input string tag);
    int lat;
    exp_t e;
    exp_q.push_back('{wd, en});
    do_cmd(2'd1, wd, 1'b0, lat);
    e = exp_q.pop_front();
    chk({tag, " lat"}, lat, elat);
    chk({tag, " nak"}, r_nak, e.n);
    chk({tag, " rxcnt"}, rx_q.size(), 1);
    if (rx_q.size() > 0) chk({tag, " byte"}, rx_q.pop_front(), e.b);
  endtask
  task automatic rd(input logic a, input logic [7:0] ed, input string tag);
    int lat;
    mack_oe = 1'bx;
    do_cmd(2'd2, 8'h00, a, lat);
    chk({tag, " lat"}, lat, LBIT);
    chk({tag, " rdata"}, r_rdata, ed);
    chk({tag, " nak"}, r_nak, 0);
    chk({tag, " slot9 sda_oe"}, mack_oe, a);
  endtask
  initial begin
    int lat, n0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst sda_oe", sda_oe, 0);
    chk("rst scl_oe", scl_oe, 0);
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst nak", nak, 0);
    chk("rst rdata", rdata, 0);
    n0 = rsp_cnt;
    repeat (100) @(posedge clk);
    #1;
    chk("idle rsp pulses", rsp_cnt - n0, 0);
    chk("idle lines", {sda_oe, scl_oe, cmd_ready, busy}, 4'b0010);
    @(negedge clk);
    cmd = 2'd0; cmd_valid = 1'b1;
    @(negedge clk) cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    n0 = rsp_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst lines", {sda_oe, scl_oe, cmd_ready, busy}, 4'b0010);
    @(negedge clk) rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("midrst rsp pulses", rsp_cnt - n0, 0);
    ss(2'd0, 1'b1, "start");
    wr(8'hE0, 1'b0, LBIT, "wr E0");
    wr(8'h0A, 1'b0, LBIT, "wr 0A");
    wr(8'h55, 1'b0, LBIT, "wr 55");
    ss(2'd3, 1'b0, "stop");
    chk("stop lines", {sda_oe, scl_oe}, 2'b00);
    do_cmd(2'd1, 8'h99, 1'b0, lat);
    chk("idle wr lat", lat, 1);
    chk("idle wr nak", r_nak, 1);
    chk("idle wr rdata", r_rdata, 0);
    chk("idle wr lines", {sda_oe, scl_oe, rx_q.size() == 0}, 3'b001);
    do_cmd(2'd3, 8'h00, 1'b0, lat);
    chk("idle stop lat", lat, 1);
    chk("idle stop nak", r_nak, 0);
    ss(2'd0, 1'b1, "start2");
    wr(8'h42, 1'b1, LBIT, "wr 42 noslave");
    ss(2'd3, 1'b0, "stop2");
    chk("noslave lines", {sda_oe, scl_oe}, 2'b00);
    ss(2'd0, 1'b1, "start3");
    wr(8'hE1, 1'b0, LBIT, "wr E1");
    rd(1'b1, 8'hA5, "rd ack");
    rd(1'b0, 8'h3C, "rd nak");
    ss(2'd3, 1'b0, "stop3");
    ss(2'd0, 1'b1, "start4");
    wr(8'hE0, 1'b0, LBIT, "wr E0 b");
    n0 = restarts;
    rise_low = 1'b0;
    ss(2'd0, 1'b1, "restart");
    chk("restart sda rise scl low", rise_low, 1);
    chk("restart detected", restarts - n0, 1);
    wr(8'hE0, 1'b0, LBIT, "wr after restart");
    ss(2'd3, 1'b0, "stop4");
    ss(2'd0, 1'b1, "start5");
    rel_n = 0;
    arm = 1'b1;
`ifdef I2C_MASTER_STRETCH_EN
    wr(8'hE0, 1'b0, LBIT + 40, "wr stretched");
`else
    do_cmd(2'd1, 8'h42, 1'b0, lat);
    chk("wr blind lat", lat, LBIT);
`endif
    arm = 1'b0;
    ss(2'd3, 1'b0, "stop5");
    chk("final lines", {sda_oe, scl_oe, busy}, 3'b000);
    chk("scoreboard empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
